ram_burst_ctrl: RTL and testbench
=================================

# ram_burst_ctrl

Burst sequencer sitting directly upstream of the 32×8 single-port RAM. Accepts one write or read burst request at a time over a valid/ready handshake and streams write beats in or read beats out. Drives the RAM's address, write-enable and data-in pins, and consumes its data-out. Accounts for the RAM's registered-address read path, where data appears the cycle after the address edge.

## Interface
- DATA_W, 8: data beat width.
- ADDR_W, 6: RAM address width.
- DEPTH, 32: number of valid RAM entries; addresses ≥ DEPTH are illegal.
- LEN_W, 6: burst length field width; the field holds beats − 1.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in / out  1  request handshake.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  beats − 1.
- wr_valid / wr_ready  in / out  1  write-beat handshake.
- wr_data  in  DATA_W  write beat.
- rd_valid / rd_ready  out / in  1  read-beat handshake.
- rd_data  out  DATA_W  read beat, a pass-through of ram_dout.
- ram_addr  out  ADDR_W  to RAM address.
- ram_we  out  1  to RAM write enable.
- ram_din  out  DATA_W  to RAM data in.
- ram_dout  in  DATA_W  from RAM data out.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse after the final beat of a burst.
- err  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, WR, RD.
- IDLE:
  - req_ready = 1.
  - On accept, load ptr = req_addr and beats = req_len + 1, then go to WR or RD per req_write.
  - An illegal request is consumed (handshake completes), pulses err the next cycle, and stays in IDLE with no RAM access.
- WR:
  - wr_ready = 1.
  - ram_we = wr_valid; ram_addr = ptr; ram_din = wr_data.
  - Each beat (wr_valid high) writes, advances ptr and decrements beats.
  - The final beat moves to IDLE; done pulses the following cycle.
- RD:
  - ram_we = 0.
  - A registered last_addr holds the address whose data is currently on ram_dout.
  - Stall (rd_valid && !rd_ready): ram_addr = last_addr, so the RAM re-registers the same address; rd_data stays stable and nothing advances.
  - Otherwise, with beats left to issue: ram_addr = ptr. At the edge: last_addr ← ptr, ptr advances, issue count decrements, rd_valid ← 1.
  - Otherwise, with none left to issue: rd_valid ← 0 at the edge.
  - The state goes to IDLE when the last beat is accepted (rd_valid && rd_ready). done pulses the following cycle.
- Outside WR and RD, ram_we = 0 and ram_addr holds its last value.
- Address arithmetic is modulo DEPTH (wrap build) or linear; see Configuration. The beat counter is LEN_W+1 bits wide, so req_len = 63 yields 64 beats.

## Timing
- All outputs reset to 0: req_ready, wr_ready, rd_valid, busy, done, err, ram_we, ram_addr, ram_din. The state resets to IDLE.
- Reset asserted mid-burst:
  - State and all outputs clear immediately (asynchronously), and ram_we drops in the same cycle.
  - The burst is abandoned and done does not pulse.
- Request to first RAM access: 1 cycle. Accept occurs at edge N; the WR or RD state begins at cycle N+1.
- Write throughput: 1 beat per cycle while wr_valid is held high.
- Read latency: the address is issued in cycle k and rd_valid rises in cycle k+1.
- Read throughput: 1 beat per cycle while rd_ready is held high.
- done and err are registered and assert 1 cycle after the triggering event. A new request may be accepted in the same cycle that done is high.
- req_ready is low throughout WR and RD.

## Configuration
- RAM_BURST_WRAP_EN defined:
  - ptr wraps from DEPTH−1 to 0.
  - Only a request with req_addr ≥ DEPTH is illegal.
- RAM_BURST_WRAP_EN undefined:
  - A request with req_addr + req_len ≥ DEPTH is illegal. It is rejected in full, with no partial burst.
  - ptr increments linearly.

## Structure
- Shared package ram_pkg holds:
  - DATA_W, ADDR_W, DEPTH, LEN_W defaults.
  - The state enum (IDLE, WR, RD).
  - Helper function addr_next(ptr), which implements the wrap or linear increment.
- Sub-module: none for the controller logic; a single FSM module is natural.
- The bench instantiates ram_burst_ctrl together with the RAM.

## Test plan
- Write burst addr 0, len 2, data 10/11/AF, wr_valid held high → ram_we high for exactly 3 cycles at addresses 0, 1, 2; done pulses 1 cycle later.
- Read burst addr 0, len 2, rd_ready held high → rd_valid for 3 consecutive cycles with rd_data = 10, 11, AF; rd_valid first rises 2 cycles after the accept edge.
- Same read with rd_ready dropped for 3 cycles on beat 1 → rd_data holds at 11 and ram_addr holds at 1 throughout the stall; no beat is lost or duplicated.
- Write addr 30, len 3:
  - With RAM_BURST_WRAP_EN, writes occur at 30, 31, 0, 1.
  - Without it, err pulses, ram_we never rises, and the FSM returns to IDLE.
- Assert reset during beat 2 of an 8-beat write → ram_we drops in the same cycle, busy = 0, done never pulses, and the next request is accepted normally.
- Write with wr_valid gapped (1,0,1,0,1) for len 2 → exactly 3 writes occur, and done pulses after the fifth cycle.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst sequencer and its RAM.
// Build option RAM_BURST_WRAP_EN: burst addresses wrap modulo DEPTH instead of
// running linearly (and over-length linear bursts being rejected).
package ram_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 6;
  localparam int SUM_W  = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_req_t;

  // Next burst address: wraps at the top of the RAM or runs linearly.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] ptr);
`ifdef RAM_BURST_WRAP_EN
    return (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
`else
    return ptr + 1'b1;
`endif
  endfunction

  // A request is illegal if it would touch an address at or above DEPTH.
  function automatic logic req_illegal(input burst_req_t r);
`ifdef RAM_BURST_WRAP_EN
    return (SUM_W'(r.addr) >= SUM_W'(DEPTH)) || (r.len != r.len);
`else
    return (SUM_W'(r.addr) + SUM_W'(r.len)) >= SUM_W'(DEPTH);
`endif
  endfunction
endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Request, beat-stream and RAM-pin bundle for ram_burst_ctrl.
// slave = the controller, master = the host/RAM side.
interface ram_burst_ctrl_if;
  import ram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, ram_dout,
    output req_ready, wr_ready, rd_valid, rd_data, ram_addr, ram_we, ram_din, busy, done, err
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, ram_dout,
    input  req_ready, wr_ready, rd_valid, rd_data, ram_addr, ram_we, ram_din, busy, done, err
  );
endinterface

// File: rtl/ram_sp.sv
// 32x8 single-port RAM with a registered read address: data for the address
// presented at edge k is on dout during the following cycle.
module ram_sp
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0]     addr_q;

  // Write port plus read-address register; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (we && (addr < ADDR_W'(DEPTH))) mem[addr[IW-1:0]] <= din;
    addr_q <= addr[IW-1:0];
  end

  assign dout = mem[addr_q];
endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of the single-port RAM: accepts one write or read
// burst at a time and streams beats to/from the RAM.
// Build option RAM_BURST_WRAP_EN selects wrapping burst addresses
// (see ram_pkg::addr_next / req_illegal).
module ram_burst_ctrl
  import ram_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  ram_burst_ctrl_if.slave bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;   // address whose data is on ram_dout
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;   // keeps ram_addr steady outside bursts
  logic [LEN_W:0]    beats_q, beats_d;           // WR: beats left; RD: beats left to issue
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  burst_req_t        req;

  assign req = '{write: bus.req_write, addr: bus.req_addr, len: bus.req_len};

  // Next-state, counters and RAM pin drive.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_addr_d = last_addr_q;
    beats_d     = beats_q;
    rd_valid_d  = rd_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ram_addr    = addr_hold_q;
    ram_we      = 1'b0;
    ram_din     = '0;
    case (state_q)
      IDLE: begin
        rd_valid_d = 1'b0;
        if (bus.req_valid && req_ready_q) begin
          if (req_illegal(req)) begin
            err_d = 1'b1;                        // consumed, no RAM access
          end else begin
            ptr_d   = req.addr;
            beats_d = {1'b0, req.len} + 1'b1;
            state_d = req.write ? WR : RD;
          end
        end
      end
      WR: begin
        ram_addr = ptr_q;
        ram_din  = bus.wr_data;
        if (bus.wr_valid) begin
          ram_we  = 1'b1;
          ptr_d   = addr_next(ptr_q);
          beats_d = beats_q - 1'b1;
          if (beats_q == 1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD: begin
        if (rd_valid_q && !bus.rd_ready) begin
          // Stall: re-register the same address so ram_dout stays put.
          ram_addr = last_addr_q;
        end else if (beats_q != 0) begin
          ram_addr    = ptr_q;
          last_addr_d = ptr_q;
          ptr_d       = addr_next(ptr_q);
          beats_d     = beats_q - 1'b1;
          rd_valid_d  = 1'b1;
        end else begin
          ram_addr   = last_addr_q;
          rd_valid_d = 1'b0;
          if (rd_valid_q) begin                  // final beat taken this cycle
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    addr_hold_d = ram_addr;
    req_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WR);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any burst immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_addr_q <= '0;
      addr_hold_q <= '0;
      beats_q     <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_addr_q <= last_addr_d;
      addr_hold_q <= addr_hold_d;
      beats_q     <= beats_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = bus.ram_dout;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_we    = ram_we;
  assign bus.ram_din   = ram_din;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl + ram_sp: write/read scoreboards fed by the
// stimulus and drained by a negedge monitor, plus inline timing checks.
module tb_ram_burst_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   we_cnt = 0;

  logic [13:0] exp_wr [$];   // {addr, data}
  logic [7:0]  exp_rd [$];
  logic [13:0] ew;
  logic [7:0]  er;
  logic [7:0]  wd [0:15];

  ram_burst_ctrl_if bus();

  ram_burst_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  ram_sp u_ram (.clk(clk), .we(bus.ram_we), .addr(bus.ram_addr),
                .din(bus.ram_din), .dout(bus.ram_dout));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    checks++;
    assert (cond) else begin
      failures++;
      $error("FAIL %s condition not met", tag);
    end
  endtask

  function automatic logic [5:0] m_next(input logic [5:0] p);
`ifdef RAM_BURST_WRAP_EN
    return (p == 6'd31) ? 6'd0 : p + 6'd1;
`else
    return p + 6'd1;
`endif
  endfunction

  // Scoreboard monitor: every RAM write and every accepted read beat.
  always @(negedge clk) begin
    if (bus.ram_we) begin
      we_cnt++;
      check_true("wr_expected", exp_wr.size() != 0);
      if (exp_wr.size() != 0) begin
        ew = exp_wr.pop_front();
        check("wr_addr", 32'(bus.ram_addr), 32'(ew[13:8]));
        check("wr_data", 32'(bus.ram_din), 32'(ew[7:0]));
      end
    end
    if (bus.rd_valid && bus.rd_ready) begin
      check_true("rd_expected", exp_rd.size() != 0);
      if (exp_rd.size() != 0) begin
        er = exp_rd.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(er));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle; returns #1 after the accept edge.
  task automatic do_req(input logic w, input logic [5:0] a, input logic [5:0] l);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_len   = l;
    @(negedge clk);
    check("req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Write burst with wr_valid held high, data from wd[]; ends in the done cycle.
  task automatic wr_burst(input logic [5:0] a, input logic [5:0] l);
    logic [5:0] ma;
    ma = a;
    for (int i = 0; i <= int'(l); i++) begin
      exp_wr.push_back({ma, wd[i]});
      ma = m_next(ma);
    end
    we_cnt = 0;
    do_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = wd[i];
      @(negedge clk);
      check("wr_we", 32'(bus.ram_we), 32'd1);
      check("wr_ready", 32'(bus.wr_ready), 32'd1);
      check("wr_req_ready_low", 32'(bus.req_ready), 32'd0);
      check("wr_done_early", 32'(bus.done), 32'd0);
      tick();
    end
    bus.wr_valid = 1'b0;
    check("wr_done", 32'(bus.done), 32'd1);
    check("wr_busy_end", 32'(bus.busy), 32'd0);
    check("wr_cnt", 32'(we_cnt), 32'(l) + 32'd1);
  endtask

  // Read burst with rd_ready held high; caller pushes expected data.
  task automatic rd_burst(input logic [5:0] a, input logic [5:0] l);
    bus.rd_ready = 1'b1;
    do_req(1'b0, a, l);
    check("rd_lat_low", 32'(bus.rd_valid), 32'd0);
    check("rd_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i <= int'(l); i++) begin
      tick();
      check("rd_valid", 32'(bus.rd_valid), 32'd1);
    end
    tick();
    check("rd_done", 32'(bus.done), 32'd1);
    check("rd_valid_end", 32'(bus.rd_valid), 32'd0);
    check("rd_sb_empty", 32'(exp_rd.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_we", 32'(bus.ram_we), 32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_din", 32'(bus.ram_din), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Write 10/11/AF at 0..2, then read back (issued in the done cycle)
    wd[0] = 8'h10; wd[1] = 8'h11; wd[2] = 8'hAF;
    wr_burst(6'd0, 6'd2);
    exp_rd.push_back(8'h10); exp_rd.push_back(8'h11); exp_rd.push_back(8'hAF);
    rd_burst(6'd0, 6'd2);

    // Same read with a 3-cycle stall on beat 1
    tick();
    exp_rd.push_back(8'h10); exp_rd.push_back(8'h11); exp_rd.push_back(8'hAF);
    bus.rd_ready = 1'b1;
    do_req(1'b0, 6'd0, 6'd2);
    tick();
    tick();
    bus.rd_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rd_valid), 32'd1);
      check("stall_data", 32'(bus.rd_data), 32'h11);
      check("stall_addr", 32'(bus.ram_addr), 32'd1);
      tick();
    end
    bus.rd_ready = 1'b1;
    tick();
    tick();
    check("stall_done", 32'(bus.done), 32'd1);
    check("stall_sb_empty", 32'(exp_rd.size()), 32'd0);
    tick();

    // Legal burst ending exactly at the top address
    wd[0] = 8'h28; wd[1] = 8'h29; wd[2] = 8'h2A; wd[3] = 8'h2B;
    wr_burst(6'd28, 6'd3);
    tick();

    // Burst crossing the top of the RAM
    wd[0] = 8'h30; wd[1] = 8'h31; wd[2] = 8'h32; wd[3] = 8'h33;
`ifdef RAM_BURST_WRAP_EN
    wr_burst(6'd30, 6'd3);
    exp_rd.push_back(8'h30); exp_rd.push_back(8'h31);
    exp_rd.push_back(8'h32); exp_rd.push_back(8'h33);
    rd_burst(6'd30, 6'd3);
`else
    we_cnt = 0;
    bus.wr_valid = 1'b1;
    do_req(1'b1, 6'd30, 6'd3);
    check("ill_err", 32'(bus.err), 32'd1);
    check("ill_busy", 32'(bus.busy), 32'd0);
    check("ill_we", 32'(bus.ram_we), 32'd0);
    check("ill_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check("ill_err_pulse", 32'(bus.err), 32'd0);
    bus.wr_valid = 1'b0;
    check("ill_we_cnt", 32'(we_cnt), 32'd0);
`endif
    tick();

    // Reset during beat 2 of an 8-beat write
    exp_wr.push_back({6'd8, 8'hC0});
    exp_wr.push_back({6'd9, 8'hC1});
    do_req(1'b1, 6'd8, 6'd7);
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hC0 + 8'(i);
      @(negedge clk);
      check("rst_mid_we", 32'(bus.ram_we), 32'd1);
      tick();
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hC2;
    #1;
    check("rst_mid_pre_we", 32'(bus.ram_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_we_drop", 32'(bus.ram_we), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_mid_addr", 32'(bus.ram_addr), 32'd0);
    bus.wr_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", 32'(bus.done), 32'd0);
      tick();
    end
    check("rst_sb_empty", 32'(exp_wr.size()), 32'd0);
    wd[0] = 8'hC8; wd[1] = 8'hC9;
    wr_burst(6'd20, 6'd1);
    exp_rd.push_back(8'hC8); exp_rd.push_back(8'hC9);
    rd_burst(6'd20, 6'd1);
    tick();
    exp_rd.push_back(8'hC0); exp_rd.push_back(8'hC1);
    rd_burst(6'd8, 6'd1);
    tick();

    // Gapped write: wr_valid 1,0,1,0,1 for a 3-beat burst
    exp_wr.push_back({6'd4, 8'h21});
    exp_wr.push_back({6'd5, 8'h22});
    exp_wr.push_back({6'd6, 8'h23});
    we_cnt = 0;
    do_req(1'b1, 6'd4, 6'd2);
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = (i % 2 == 0);
      bus.wr_data  = 8'h21 + 8'(i / 2);
      @(negedge clk);
      check("gap_we", 32'(bus.ram_we), 32'(bus.wr_valid));
      check("gap_done_early", 32'(bus.done), 32'd0);
      tick();
    end
    bus.wr_valid = 1'b0;
    check("gap_done", 32'(bus.done), 32'd1);
    check("gap_cnt", 32'(we_cnt), 32'd3);
    exp_rd.push_back(8'h21); exp_rd.push_back(8'h22); exp_rd.push_back(8'h23);
    rd_burst(6'd4, 6'd2);

    tick();
    tick();
    check("final_wr_sb", 32'(exp_wr.size()), 32'd0);
    check("final_rd_sb", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
